// File: rtl/bcd_scan_counter_if.sv
// Bus bundle between bcd_scan_counter and its user/display path.
// master drives en/clr; slave (the counter) drives the display outputs.
interface bcd_scan_counter_if;
  logic        en;
  logic        clr;
  logic [15:0] count;
  logic        carry;
  logic [3:0]  bcd;
  logic [3:0]  dig_sel;
  logic        blank;

  modport master (
    output en,
    output clr,
    input  count,
    input  carry,
    input  bcd,
    input  dig_sel,
    input  blank
  );

  modport slave (
    input  en,
    input  clr,
    output count,
    output carry,
    output bcd,
    output dig_sel,
    output blank
  );
endinterface

// File: rtl/bcd_scan_counter.sv
// Four-digit BCD up-counter with a time-multiplexed digit scanner.
// Define BCD_SCAN_LEADING_ZERO_BLANK_EN to enable leading-zero blanking.
module bcd_scan_counter #(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  bcd_scan_counter_if.slave bus
);

  localparam logic [7:0] PRESC_MAX = 8'(SCAN_DIV - 1);

  logic [15:0] count_q;
  logic [15:0] count_n;
  logic        carry_q;
  logic        carry_n;
  logic [3:0]  inc;
  logic [7:0]  presc_q;
  logic [7:0]  presc_n;
  logic        presc_wrap;
  logic [1:0]  idx_q;
  logic [1:0]  idx_n;
  logic [3:0]  sel_q;
  logic [3:0]  sel_n;
  logic [3:0]  bcd_q;
  logic [3:0]  bcd_n;
  logic        blank_q;
  logic        blank_n;

  // Next count: digit i steps when en and all lower digits are 9
  always_comb begin
    count_n = count_q;
    inc     = '0;
    inc[0]  = bus.en;
    for (int i = 1; i < 4; i++) begin
      inc[i] = inc[i-1] && (count_q[4*(i-1) +: 4] == 4'd9);
    end
    for (int i = 0; i < 4; i++) begin
      if (inc[i]) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          count_n[4*i +: 4] = 4'd0;
        end else begin
          count_n[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
        end
      end
    end
    carry_n = inc[3] && (count_q[15:12] == 4'd9);
    if (bus.clr) begin
      count_n = '0;
      carry_n = 1'b0;
    end
  end

  // Free-running prescaler and digit index
  always_comb begin
    presc_wrap = (presc_q == PRESC_MAX);
    presc_n    = presc_wrap ? 8'd0 : presc_q + 8'd1;
    idx_n      = idx_q + {1'b0, presc_wrap};
  end

  // Display word built from the index being entered this edge
  always_comb begin
    sel_n = 4'b0001 << idx_n;
    bcd_n = count_q[{idx_n, 2'b00} +: 4];
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
    unique case (1'b1)
      (idx_n == 2'd1): blank_n = (count_q[15:4] == 12'd0);
      (idx_n == 2'd2): blank_n = (count_q[15:8] == 8'd0);
      (idx_n == 2'd3): blank_n = (count_q[15:12] == 4'd0);
      default:         blank_n = 1'b0;
    endcase
`else
    blank_n = 1'b0;
`endif
  end

  // Count and wrap pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      carry_q <= 1'b0;
    end else begin
      count_q <= count_n;
      carry_q <= carry_n;
    end
  end

  // Scanner state, independent of en/clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      presc_q <= presc_n;
      idx_q   <= idx_n;
    end
  end

  // Display outputs updated together so fnd never sees a split pair
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= 4'b0001;
      bcd_q   <= '0;
      blank_q <= 1'b0;
    end else begin
      sel_q   <= sel_n;
      bcd_q   <= bcd_n;
      blank_q <= blank_n;
    end
  end

  assign bus.count   = count_q;
  assign bus.carry   = carry_q;
  assign bus.bcd     = bcd_q;
  assign bus.dig_sel = sel_q;
  assign bus.blank   = blank_q;

endmodule
